eq_band_scheduler: RTL and testbench
====================================

Name: eq_band_scheduler

Overview:
- Controller for the three-band parametric EQ.
- Owns the per-band biquad coefficient bank, written by the MCU over the SPI register interface and double-buffered so it commits only at sample boundaries.
- On each new ADC sample it time-multiplexes one shared biquad engine across bands 0..2 (low/mid/high) using a start/done handshake.
- It sums the band results with saturation and presents one output sample per input sample to the DAC path.

Parameters:
- DATA_W, 16: signed sample width (ADC in, engine result, DAC out).
- COEF_W, 16: signed coefficient width, Q2.14 format (0x4000 = 1.0).
- NBANDS, 3: number of bands sequenced per sample.
- TIMEOUT, 64: max cycles to wait for eng_done before aborting a band.

Ports:
- clk  in  1  system clock (6 MHz HSOSC).
- reset  in  1  asynchronous, active-low reset.
- sample_valid  in  1  one-cycle strobe; new input sample present.
- sample_in  in  DATA_W  signed input sample.
- wr_en  in  1  coefficient write strobe from SPI register block.
- wr_addr  in  4  {band[1:0], idx[1:0]}. idx 0..3 = b0,b1,b2,a1. a2 uses the separate address below.
- wr_a2  in  1  when 1, the write targets a2 of wr_addr band (idx ignored).
- wr_data  in  COEF_W  coefficient value.
- commit  in  1  one-cycle strobe; request shadow-to-active copy.
- ovr_clr  in  1  clears sticky status flags.
- eng_start  out  1  one-cycle start to the biquad engine.
- eng_band  out  2  band index for the engine's state registers.
- eng_sample  out  DATA_W  captured input sample.
- eng_coef  out  5*COEF_W  {b0,b1,b2,a1,a2} of the active bank for eng_band.
- eng_done  in  1  one-cycle completion from the engine.
- eng_result  in  DATA_W  band output; valid with eng_done.
- out_valid  out  1  one-cycle strobe; out_sample valid.
- out_sample  out  DATA_W  saturated sum of band results.
- busy  out  1  high from sample capture until out_valid.
- overrun  out  1  sticky; a sample_valid arrived while busy.
- timeout_err  out  1  sticky; a band timed out.

Behaviour:
- Reset values:
  - All outputs 0.
  - State IDLE.
  - Shadow and active banks: band0 b0 = 0x4000, every other coefficient 0, giving unity passthrough.
  - Commit-pending flag 0.
- FSM states: IDLE, ISSUE, WAIT, SUM.
  - IDLE + sample_valid: capture sample_in into eng_sample; clear the accumulator; band := 0; go to ISSUE.
  - ISSUE: assert eng_start for one cycle with eng_band and eng_coef; load the timeout counter; go to WAIT.
  - WAIT + eng_done: add sign-extended eng_result into a (DATA_W+2)-bit accumulator.
    - If band < NBANDS-1: band++ and go to ISSUE.
    - Otherwise go to SUM.
  - WAIT + counter reaches TIMEOUT: contribute 0 for that band, set timeout_err, advance exactly as for done.
  - SUM: saturate the accumulator to signed DATA_W (clamp to 0x7FFF / 0x8000); pulse out_valid; go to IDLE.
  - eng_done while not in WAIT is ignored.
- Latency: with sample_valid at cycle T and engine latency L (done L cycles after start):
  - eng_start at T+1, T+2+L, T+3+2L.
  - out_valid at T+4+3L.
  - out_sample holds its value until the next out_valid.
- Overrun: sample_valid while busy is dropped and sets overrun. The in-flight sequence is unaffected.
- Coefficient writes:
  - Go to the shadow bank at any time.
  - Band index 3 is ignored.
  - The active bank never changes mid-sequence.
- Commit:
  - A commit pulse sets pending.
  - When pending and state == IDLE, active <= shadow and pending clears. This happens in the same cycle as a sample capture if both coincide, so the new bank applies to that sample.
  - A write in the same cycle as the copy is not included in the copy. It lands in shadow and needs a new commit.
- ovr_clr clears overrun and timeout_err. If a set event occurs in the same cycle, set wins.
- Reset mid-sequence: return immediately to IDLE; banks go to reset defaults; no out_valid is issued.

Optional Feature:
- Macro: EQ_BAND_MUTE_EN.
- When defined, adds input port mute_mask [NBANDS-1:0]. It is sampled at capture (IDLE + sample_valid).
  - A muted band is skipped: no eng_start, no wait, contributes 0.
  - If all bands are muted, go ISSUE-free straight to SUM: out_valid at T+2, out_sample = 0.
- When undefined: no port, all bands always issued.

Decomposition:
- Package eq_pkg holds:
  - DATA_W, COEF_W, NBANDS.
  - typedef coef_t (signed COEF_W).
  - typedef biquad_coefs_t (struct b0,b1,b2,a1,a2).
  - typedef sched_state_t (enum IDLE, ISSUE, WAIT, SUM).
  - COEF_ONE = 16'h4000.
- One sub-module: eq_coef_bank. It contains the shadow/active register file, write decode, commit-pending logic and read mux by band.

Test Plan:
- Reset, no writes, engine model passes sample through for band0 and returns 0 for others, L=4: sample_in=0x1234 at T -> out_valid at T+16, out_sample=0x1234.
- Engine returns 0x6000 for all three bands -> out_sample=0x7FFF (positive clamp). Engine returns 0x9000 for all three -> out_sample=0x8000.
- Write band1 b0=0x2000, then commit mid-sequence -> current sample still sees band1 eng_coef b0=0; next sample sees 0x2000.
- Second sample_valid 3 cycles after the first -> dropped, overrun=1, one out_valid only; ovr_clr -> overrun=0.
- Engine never asserts done for band2 -> timeout_err=1 after 64 WAIT cycles; out_valid follows, out_sample = band0 + band1 sum.
- EQ_BAND_MUTE_EN, mute_mask=3'b010 -> only bands 0 and 2 get eng_start. mute_mask=3'b111 -> out_valid at T+2 with 0.

Source files
------------

// File: rtl/eq_band_scheduler_pkg.sv
// rtl/eq_band_scheduler_pkg.sv - shared widths, types and helpers for the three-band EQ scheduler
package eq_pkg;

  localparam int DATA_W = 16;
  localparam int COEF_W = 16;
  localparam int NBANDS = 3;
  localparam int ACC_W  = DATA_W + 2;

  typedef logic signed [COEF_W-1:0] coef_t;

  localparam coef_t COEF_ONE = 16'h4000;

  typedef struct packed {
    coef_t b0;
    coef_t b1;
    coef_t b2;
    coef_t a1;
    coef_t a2;
  } biquad_coefs_t;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, SUM} sched_state_t;

  // Unity passthrough: only band 0 b0 is 1.0.
  function automatic biquad_coefs_t reset_coefs(input int band);
    biquad_coefs_t c;
    c = '0;
    if (band == 0) c.b0 = COEF_ONE;
    return c;
  endfunction

  // Returns {found, index} of the lowest unmuted band at or above 'from'.
  function automatic logic [2:0] first_band(input logic [NBANDS-1:0] mute, input logic [2:0] from);
    logic [2:0] r;
    r = '0;
    for (int b = NBANDS - 1; b >= 0; b--) begin
      if (b >= int'(from) && !mute[b]) r = {1'b1, 2'(b)};
    end
    return r;
  endfunction

  function automatic logic [DATA_W-1:0] sat_acc(input logic [ACC_W-1:0] a);
    if (a[ACC_W-1:DATA_W-1] == '0 || a[ACC_W-1:DATA_W-1] == '1) return a[DATA_W-1:0];
    else if (a[ACC_W-1]) return {1'b1, {(DATA_W-1){1'b0}}};
    else return {1'b0, {(DATA_W-1){1'b1}}};
  endfunction

endpackage

// File: rtl/eq_band_scheduler_if.sv
// rtl/eq_band_scheduler_if.sv - start/done handshake between the scheduler and the shared biquad engine
interface eq_band_scheduler_if;
  import eq_pkg::*;

  logic                  eng_start;
  logic [1:0]            eng_band;
  logic [DATA_W-1:0]     eng_sample;
  logic [5*COEF_W-1:0]   eng_coef;
  logic                  eng_done;
  logic [DATA_W-1:0]     eng_result;

  modport master (
    output eng_start, eng_band, eng_sample, eng_coef,
    input  eng_done, eng_result
  );

  modport slave (
    input  eng_start, eng_band, eng_sample, eng_coef,
    output eng_done, eng_result
  );

endinterface

// File: rtl/eq_band_scheduler_coef_bank.sv
// rtl/eq_band_scheduler_coef_bank.sv - double-buffered per-band coefficient bank
// Shadow takes MCU writes at any time; active is copied from shadow only while the scheduler is idle.
module eq_coef_bank
  import eq_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                wr_en,
  input  logic [3:0]          wr_addr,
  input  logic                wr_a2,
  input  logic [COEF_W-1:0]   wr_data,
  input  logic                commit,
  input  logic                idle,
  input  logic [1:0]          rd_band,
  output biquad_coefs_t       rd_coefs
);

  biquad_coefs_t shadow_q [NBANDS];
  biquad_coefs_t shadow_d [NBANDS];
  biquad_coefs_t active_q [NBANDS];
  biquad_coefs_t active_d [NBANDS];
  logic          pending_q, pending_d;
  logic          copy;

  always_comb begin
    copy      = pending_q && idle;
    pending_d = commit || (pending_q && !copy);
    for (int b = 0; b < NBANDS; b++) begin
      shadow_d[b] = shadow_q[b];
      // Copy reads the pre-write shadow, so a same-cycle write waits for the next commit.
      active_d[b] = copy ? shadow_q[b] : active_q[b];
    end
    if (wr_en && int'(wr_addr[3:2]) < NBANDS) begin
      if (wr_a2) begin
        shadow_d[wr_addr[3:2]].a2 = wr_data;
      end else begin
        case (wr_addr[1:0])
          2'd0:    shadow_d[wr_addr[3:2]].b0 = wr_data;
          2'd1:    shadow_d[wr_addr[3:2]].b1 = wr_data;
          2'd2:    shadow_d[wr_addr[3:2]].b2 = wr_data;
          default: shadow_d[wr_addr[3:2]].a1 = wr_data;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int b = 0; b < NBANDS; b++) begin
        shadow_q[b] <= reset_coefs(b);
        active_q[b] <= reset_coefs(b);
      end
      pending_q <= 1'b0;
    end else begin
      shadow_q  <= shadow_d;
      active_q  <= active_d;
      pending_q <= pending_d;
    end
  end

  assign rd_coefs = (int'(rd_band) < NBANDS) ? active_q[rd_band] : '0;

endmodule

// File: rtl/eq_band_scheduler.sv
// rtl/eq_band_scheduler.sv - sequences the shared biquad engine over three bands and sums with saturation
// Optional per-band muting is enabled with EQ_BAND_MUTE_EN.
module eq_band_scheduler
  import eq_pkg::*;
#(
  parameter int TIMEOUT = 64
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                sample_valid,
  input  logic [DATA_W-1:0]   sample_in,
  input  logic                wr_en,
  input  logic [3:0]          wr_addr,
  input  logic                wr_a2,
  input  logic [COEF_W-1:0]   wr_data,
  input  logic                commit,
  input  logic                ovr_clr,
`ifdef EQ_BAND_MUTE_EN
  input  logic [NBANDS-1:0]   mute_mask,
`endif
  eq_band_scheduler_if.master eng,
  output logic                out_valid,
  output logic [DATA_W-1:0]   out_sample,
  output logic                busy,
  output logic                overrun,
  output logic                timeout_err
);

  localparam int TW = $clog2(TIMEOUT) + 1;

  localparam logic [1:0] ST_IDLE  = IDLE;
  localparam logic [1:0] ST_ISSUE = ISSUE;
  localparam logic [1:0] ST_WAIT  = WAIT;
  localparam logic [1:0] ST_SUM   = SUM;

  logic [1:0]        state_q, state_d;
  logic [1:0]        band_q, band_d;
  logic [DATA_W-1:0] sample_q, sample_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [TW-1:0]     tmo_q, tmo_d;
  logic [NBANDS-1:0] mute_q, mute_d, mute_now;
  logic [DATA_W-1:0] out_q, out_d;
  logic              ovr_q, ovr_d;
  logic              tmo_err_q, tmo_err_d;
  logic [2:0]        pick;
  logic              band_tmo;
  biquad_coefs_t     rd_coefs;

`ifdef EQ_BAND_MUTE_EN
  assign mute_now = mute_mask;
`else
  assign mute_now = '0;
`endif

  eq_coef_bank u_bank (
    .clk      (clk),
    .reset    (reset),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_a2    (wr_a2),
    .wr_data  (wr_data),
    .commit   (commit),
    .idle     (state_q == ST_IDLE),
    .rd_band  (band_q),
    .rd_coefs (rd_coefs)
  );

  always_comb begin
    state_d  = state_q;
    band_d   = band_q;
    sample_d = sample_q;
    acc_d    = acc_q;
    tmo_d    = tmo_q;
    mute_d   = mute_q;
    out_d    = out_q;
    pick     = '0;
    band_tmo = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (sample_valid) begin
          sample_d = sample_in;
          acc_d    = '0;
          mute_d   = mute_now;
          pick     = first_band(mute_now, 3'd0);
          band_d   = pick[1:0];
          state_d  = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        tmo_d = '0;
        // Only reachable with a muted band when every band is muted.
        state_d = mute_q[band_q] ? ST_SUM : ST_WAIT;
      end
      ST_WAIT: begin
        band_tmo = !eng.eng_done && (tmo_q == TW'(TIMEOUT - 1));
        if (eng.eng_done) begin
          acc_d = acc_q + {{(ACC_W-DATA_W){eng.eng_result[DATA_W-1]}}, eng.eng_result};
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
        if (eng.eng_done || band_tmo) begin
          pick = first_band(mute_q, {1'b0, band_q} + 3'd1);
          if (pick[2]) begin
            band_d  = pick[1:0];
            state_d = ST_ISSUE;
          end else begin
            state_d = ST_SUM;
          end
        end
      end
      ST_SUM:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (state_d == ST_SUM && state_q != ST_SUM) out_d = sat_acc(acc_d);
  end

  // Sticky flags: a set event in the same cycle as ovr_clr wins.
  assign ovr_d     = (sample_valid && state_q != ST_IDLE) || (ovr_q && !ovr_clr);
  assign tmo_err_d = band_tmo || (tmo_err_q && !ovr_clr);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      band_q    <= '0;
      sample_q  <= '0;
      acc_q     <= '0;
      tmo_q     <= '0;
      mute_q    <= '0;
      out_q     <= '0;
      ovr_q     <= 1'b0;
      tmo_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      band_q    <= band_d;
      sample_q  <= sample_d;
      acc_q     <= acc_d;
      tmo_q     <= tmo_d;
      mute_q    <= mute_d;
      out_q     <= out_d;
      ovr_q     <= ovr_d;
      tmo_err_q <= tmo_err_d;
    end
  end

  assign eng.eng_start  = (state_q == ST_ISSUE) && !mute_q[band_q];
  assign eng.eng_band   = band_q;
  assign eng.eng_sample = sample_q;
  assign eng.eng_coef   = (state_q == ST_ISSUE) ? rd_coefs : '0;
  assign out_valid      = (state_q == ST_SUM);
  assign out_sample     = out_q;
  assign busy           = (state_q != ST_IDLE);
  assign overrun        = ovr_q;
  assign timeout_err    = tmo_err_q;

endmodule

// File: tb/tb_eq_band_scheduler.sv
// tb/tb_eq_band_scheduler.sv - self-checking bench: vector table, directed corner sequences, random vs reference
module tb_eq_band_scheduler;
  import eq_pkg::*;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              sample_valid = 1'b0;
  logic [15:0]       sample_in = '0;
  logic              wr_en = 1'b0;
  logic [3:0]        wr_addr = '0;
  logic              wr_a2 = 1'b0;
  logic [15:0]       wr_data = '0;
  logic              commit = 1'b0;
  logic              ovr_clr = 1'b0;
  logic              out_valid;
  logic [15:0]       out_sample;
  logic              busy, overrun, timeout_err;
`ifdef EQ_BAND_MUTE_EN
  logic [NBANDS-1:0] mute_mask = '0;
`endif

  eq_band_scheduler_if eng();

  eq_band_scheduler #(.TIMEOUT(64)) dut (
    .clk(clk), .reset(reset), .sample_valid(sample_valid), .sample_in(sample_in),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_a2(wr_a2), .wr_data(wr_data),
    .commit(commit), .ovr_clr(ovr_clr),
`ifdef EQ_BAND_MUTE_EN
    .mute_mask(mute_mask),
`endif
    .eng(eng), .out_valid(out_valid), .out_sample(out_sample),
    .busy(busy), .overrun(overrun), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;

  // Engine stand-in: mode 0 = sample*b0 in Q2.14, 1 = constant, 2 = per-band table.
  int          eng_mode = 0;
  int          eng_lat = 4;
  int          eng_hang = -1;
  logic [15:0] eng_const = '0;
  logic [15:0] eng_tab [3];
  int          e_cnt = 0;
  bit          e_pend = 0;
  logic [15:0] e_res;

  always @(negedge clk) begin
    logic signed [31:0] p;
    eng.eng_done = 1'b0;
    if (!reset) begin
      e_pend = 0;
      eng.eng_result = '0;
    end else begin
      if (e_pend) begin
        e_cnt--;
        if (e_cnt == 0) begin
          eng.eng_done = 1'b1;
          eng.eng_result = e_res;
          e_pend = 0;
        end
      end
      if (eng.eng_start) begin
        p = $signed(eng.eng_sample) * $signed(eng.eng_coef[79:64]);
        p = p >>> 14;
        case (eng_mode)
          0:       e_res = p[15:0];
          1:       e_res = eng_const;
          default: e_res = eng_tab[eng.eng_band];
        endcase
        e_pend = (int'(eng.eng_band) != eng_hang);
        e_cnt = eng_lat;
      end
    end
  end

  typedef struct { int c; logic [1:0] band; logic [79:0] coef; logic [15:0] smp; } start_rec_t;
  start_rec_t  st_q [$];
  int          ov_c [$];
  logic [15:0] ov_v [$];

  always @(negedge clk) begin
    if (eng.eng_start) st_q.push_back('{cyc, eng.eng_band, eng.eng_coef, eng.eng_sample});
    if (out_valid) begin
      ov_c.push_back(cyc);
      ov_v.push_back(out_sample);
    end
  end

  // Reference coefficient bank: index 0..4 = b0,b1,b2,a1,a2.
  logic [15:0] m_sh [3][5];
  logic [15:0] m_ac [3][5];
  bit          m_pend;
  int          t_sent;
  logic [15:0] cur_smp;

  task automatic model_reset();
    for (int b = 0; b < 3; b++)
      for (int i = 0; i < 5; i++) begin
        m_sh[b][i] = (b == 0 && i == 0) ? 16'h4000 : 16'h0000;
        m_ac[b][i] = m_sh[b][i];
      end
    m_pend = 0;
  endtask

  function automatic logic [79:0] model_coef(input logic [1:0] b);
    if (b == 2'd3) return '0;
    return {m_ac[b][0], m_ac[b][1], m_ac[b][2], m_ac[b][3], m_ac[b][4]};
  endfunction

  function automatic logic [15:0] clamp_sum(input logic [15:0] r0, input logic [15:0] r1, input logic [15:0] r2);
    int s;
    s = int'($signed(r0)) + int'($signed(r1)) + int'($signed(r2));
    if (s > 32767) s = 32767;
    if (s < -32768) s = -32768;
    return 16'(s);
  endfunction

  task automatic check(input string nm, input logic [79:0] act, input logic [79:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic tb_write(input logic [1:0] b, input logic [1:0] idx, input logic a2, input logic [15:0] d);
    wr_en = 1'b1; wr_addr = {b, idx}; wr_a2 = a2; wr_data = d;
    tick();
    wr_en = 1'b0;
    if (b != 2'd3) begin
      if (a2) m_sh[b][4] = d;
      else m_sh[b][idx] = d;
    end
  endtask

  task automatic tb_commit();
    commit = 1'b1;
    tick();
    commit = 1'b0;
    m_pend = 1;
  endtask

  task automatic send_sample(input logic [15:0] s, input int lat);
    st_q.delete(); ov_c.delete(); ov_v.delete();
    if (m_pend) begin
      m_ac = m_sh;
      m_pend = 0;
    end
    eng_lat = lat;
    cur_smp = s;
    sample_in = s;
    sample_valid = 1'b1;
    t_sent = cyc;
    tick();
    sample_valid = 1'b0;
  endtask

  task automatic finish_sample(input int exp_lat, input logic [15:0] exp_v, input string nm,
                               input int nstarts, input int step);
    bit got;
    for (int i = 0; i < 400 && ov_c.size() == 0; i++) tick();
    got = (ov_c.size() > 0);
    check({nm, "_outvalid"}, got, 1'b1);
    check({nm, "_latency"}, got ? ov_c[0] - t_sent : -1, exp_lat);
    check({nm, "_value"}, got ? ov_v[0] : 16'hxxxx, exp_v);
    check({nm, "_nstarts"}, st_q.size(), nstarts);
    foreach (st_q[k]) begin
      check({nm, "_coef"}, st_q[k].coef, model_coef(st_q[k].band));
      check({nm, "_esample"}, st_q[k].smp, cur_smp);
      if (step > 0) begin
        check({nm, "_band"}, st_q[k].band, k);
        check({nm, "_startcyc"}, st_q[k].c - t_sent, 1 + k * step);
      end
    end
    tick();
  endtask

  typedef struct { logic [15:0] smp; int mode; logic [15:0] cval; logic [15:0] exp; } vec_t;
  vec_t vt [8];

  initial begin
    vt[0] = '{16'h1234, 0, 16'h0000, 16'h1234};
    vt[1] = '{16'h0001, 1, 16'h6000, 16'h7FFF};
    vt[2] = '{16'h0001, 1, 16'h9000, 16'h8000};
    vt[3] = '{16'h0002, 1, 16'h1000, 16'h3000};
    vt[4] = '{16'h0003, 1, 16'hE000, 16'hA000};
    vt[5] = '{16'h0004, 1, 16'h2AAA, 16'h7FFE};
    vt[6] = '{16'h0005, 1, 16'h2AAB, 16'h7FFF};
    vt[7] = '{16'h8000, 0, 16'h0000, 16'h8000};

    model_reset();
    repeat (3) tick();
    check("rst_eng", {eng.eng_start, eng.eng_band, eng.eng_sample}, '0);
    check("rst_coef", eng.eng_coef, '0);
    check("rst_out", {out_valid, out_sample, busy}, '0);
    check("rst_flags", {overrun, timeout_err}, '0);
    reset = 1'b1;
    tick();
    check("post_rst_idle", {busy, out_valid, eng.eng_start}, '0);

    for (int v = 0; v < 8; v++) begin
      eng_mode = vt[v].mode;
      eng_const = vt[v].cval;
      send_sample(vt[v].smp, 4);
      finish_sample(16, vt[v].exp, $sformatf("vec%0d", v), 3, 5);
    end

    // Commit requested mid-sequence must not disturb the sample in flight.
    eng_mode = 0;
    send_sample(16'h1000, 4);
    repeat (3) tick();
    tb_write(2'd1, 2'd0, 1'b0, 16'h2000);
    tb_commit();
    begin
      logic [15:0] b0_band1;
      for (int i = 0; i < 400 && ov_c.size() == 0; i++) tick();
      b0_band1 = (st_q.size() > 1) ? st_q[1].coef[79:64] : 16'hxxxx;
      check("commit_old_b0", b0_band1, 16'h0000);
      check("commit_old_out", (ov_v.size() > 0) ? ov_v[0] : 16'hxxxx, 16'h1000);
      tick();
    end
    send_sample(16'h1000, 4);
    finish_sample(16, 16'h1800, "commit_new", 3, 5);
    check("commit_new_b0", (st_q.size() > 1) ? st_q[1].coef[79:64] : 16'hxxxx, 16'h2000);

    // Overrun: second sample 3 cycles after the first is dropped.
    eng_mode = 1; eng_const = 16'h0100;
    send_sample(16'h0055, 4);
    repeat (2) tick();
    sample_valid = 1'b1; sample_in = 16'h7777;
    tick();
    sample_valid = 1'b0;
    check("ovr_set", overrun, 1'b1);
    finish_sample(16, 16'h0300, "ovr_seq", 3, 5);
    repeat (20) tick();
    check("ovr_one_out", ov_c.size(), 1);
    ovr_clr = 1'b1; tick(); ovr_clr = 1'b0;
    check("ovr_clr", overrun, 1'b0);
    send_sample(16'h0055, 4);
    sample_valid = 1'b1; ovr_clr = 1'b1;
    tick();
    sample_valid = 1'b0; ovr_clr = 1'b0;
    check("ovr_set_wins", overrun, 1'b1);
    finish_sample(16, 16'h0300, "ovr_seq2", 3, 5);
    ovr_clr = 1'b1; tick(); ovr_clr = 1'b0;
    check("ovr_clr2", overrun, 1'b0);

    // Band 2 never completes: 64 WAIT cycles then abort with zero contribution.
    eng_mode = 0; eng_hang = 2;
    send_sample(16'h0400, 4);
    finish_sample(76, 16'h0600, "tmo", 3, 5);
    check("tmo_err_set", timeout_err, 1'b1);
    eng_hang = -1;
    ovr_clr = 1'b1; tick(); ovr_clr = 1'b0;
    check("tmo_err_clr", timeout_err, 1'b0);

    // Done on the 64th WAIT cycle is accepted; one cycle later is a timeout.
    eng_mode = 1; eng_const = 16'h0010;
    send_sample(16'h0001, 64);
    finish_sample(196, 16'h0030, "tmo_edge64", 3, 65);
    check("tmo_edge64_err", timeout_err, 1'b0);
    send_sample(16'h0001, 65);
    finish_sample(196, 16'h0000, "tmo_edge65", 3, 65);
    check("tmo_edge65_err", timeout_err, 1'b1);
    ovr_clr = 1'b1; tick(); ovr_clr = 1'b0;

`ifdef EQ_BAND_MUTE_EN
    mute_mask = 3'b010;
    send_sample(16'h0001, 4);
    finish_sample(11, 16'h0020, "mute010", 2, 0);
    check("mute010_bands", (st_q.size() == 2) ? {st_q[0].band, st_q[1].band} : 4'hx, 4'b0010);
    mute_mask = 3'b111;
    send_sample(16'h0001, 4);
    finish_sample(2, 16'h0000, "mute111", 0, 0);
    mute_mask = 3'b000;
`endif

    // Reset mid-sequence: no output, banks back to defaults.
    eng_mode = 0;
    send_sample(16'h0300, 4);
    repeat (5) tick();
    reset = 1'b0;
    tick();
    check("midrst_idle", {busy, out_valid, eng.eng_start}, '0);
    tick();
    reset = 1'b1;
    model_reset();
    repeat (30) tick();
    check("midrst_no_out", ov_c.size(), 0);
    send_sample(16'h0200, 4);
    finish_sample(16, 16'h0200, "midrst_after", 3, 5);

    // Random: bank writes (band 3 included), optional commit, random engine results and latency.
    eng_mode = 2;
    for (int it = 0; it < 30; it++) begin
      int nw;
      int lat;
      logic [15:0] expv;
      nw = int'($urandom_range(0, 2));
      for (int w = 0; w < nw; w++)
        tb_write(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 16'($urandom));
      if ($urandom_range(0, 1) == 1) tb_commit();
      for (int b = 0; b < 3; b++) eng_tab[b] = 16'($urandom);
      lat = int'($urandom_range(1, 6));
      expv = clamp_sum(eng_tab[0], eng_tab[1], eng_tab[2]);
      send_sample(16'($urandom), lat);
      finish_sample(4 + 3 * lat, expv, $sformatf("rnd%0d", it), 3, lat + 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
